// File: rtl/cic_pkg.sv
// Shared definitions for the CIC integrator, decimator and comb stages.
package cic_pkg;

    localparam int unsigned CIC_DEFAULT_DATA_W = 32;

    // Overflow/underflow flag pair passed between CIC stages
    typedef struct packed {
        logic of;
        logic uf;
    } cic_flags_t;

    localparam cic_flags_t CIC_FLAGS_NONE = '{of: 1'b0, uf: 1'b0};

    // Ceiling log2, usable in constant expressions
    function automatic int unsigned cic_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = 32'(i + 1);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/clk_rise_detect.sv
// Rising-edge pulse for a level clock that is synchronous to clk.
// History register resets high so a level already high at release is not an edge.
module clk_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise_c
);

    logic sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b1;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise_c = sig & ~sig_q;

endmodule

// File: rtl/cic_decimate_hold.sv
// CIC decimator: keeps one of every DECIM_RATIO samples, generates the divided clock and
// ORs flags over each window. Define CIC_DECIM_PHASE_SEL_EN to add the PHASE_I capture-phase select.
module cic_decimate_hold
    import cic_pkg::*;
#(
    parameter int unsigned  DATA_BIT_WIDTH = CIC_DEFAULT_DATA_W,
    parameter int unsigned  DECIM_RATIO    = 4,
    localparam int unsigned CNT_WIDTH      = cic_clog2(DECIM_RATIO)
) (
    input  logic                             MCLK_I,
    input  logic                             RST_I,
    input  logic                             CLK_I,
    input  logic signed [DATA_BIT_WIDTH-1:0] DATA_I,
    input  logic                             OFDET_I,
    input  logic                             UFDET_I,
`ifdef CIC_DECIM_PHASE_SEL_EN
    input  logic [CNT_WIDTH-1:0]             PHASE_I,
`endif
    output logic                             CLK_O,
    output logic signed [DATA_BIT_WIDTH-1:0] DATA_O,
    output logic                             OFDET_O,
    output logic                             UFDET_O
);

    localparam int unsigned SUM_W = CNT_WIDTH + 1;
    localparam int unsigned HALF  = DECIM_RATIO / 2;
    localparam logic [CNT_WIDTH-1:0] LAST_PHASE = CNT_WIDTH'(DECIM_RATIO - 1);

    logic                             rise_c;
    logic [CNT_WIDTH-1:0]             phase_cnt;
    logic [CNT_WIDTH-1:0]             phase_cnt_nxt;
    logic [CNT_WIDTH-1:0]             phase_sel;
    logic [CNT_WIDTH-1:0]             fall_phase_c;
    logic [SUM_W-1:0]                 fall_sum_c;
    logic                             wrap_c;
    logic                             capture_c;
    logic                             fall_c;
    cic_flags_t                       acc;
    cic_flags_t                       acc_nxt;
    logic signed [DATA_BIT_WIDTH-1:0] data_nxt;
    logic                             clk_o_nxt;
    logic                             of_nxt;
    logic                             uf_nxt;

    clk_rise_detect u_rise (
        .clk    (MCLK_I),
        .rst    (RST_I),
        .sig    (CLK_I),
        .rise_c (rise_c)
    );

    assign wrap_c = (phase_cnt == LAST_PHASE);

`ifdef CIC_DECIM_PHASE_SEL_EN
    // New phase takes effect only at the window boundary to avoid double or missed captures
    always_ff @(posedge MCLK_I or posedge RST_I) begin
        if (RST_I) begin
            phase_sel <= '0;
        end else if (rise_c && wrap_c) begin
            phase_sel <= (PHASE_I > LAST_PHASE) ? LAST_PHASE : PHASE_I;
        end
    end
`else
    assign phase_sel = '0;
`endif

    // Falling phase is half a window (floored) after the capture phase, modulo R
    always_comb begin
        fall_sum_c = SUM_W'(phase_sel) + SUM_W'(HALF);
        if (fall_sum_c >= SUM_W'(DECIM_RATIO)) begin
            fall_phase_c = CNT_WIDTH'(fall_sum_c - SUM_W'(DECIM_RATIO));
        end else begin
            fall_phase_c = CNT_WIDTH'(fall_sum_c);
        end
    end

    assign capture_c = rise_c && (phase_cnt == phase_sel);
    assign fall_c    = rise_c && (phase_cnt == fall_phase_c);

    // Next-state for counter, held sample, divided clock and flag windows
    always_comb begin
        phase_cnt_nxt = phase_cnt;
        acc_nxt       = acc;
        data_nxt      = DATA_O;
        clk_o_nxt     = CLK_O;
        of_nxt        = OFDET_O;
        uf_nxt        = UFDET_O;
        if (rise_c) begin
            phase_cnt_nxt = wrap_c ? '0 : phase_cnt + CNT_WIDTH'(1);
            if (capture_c) begin
                data_nxt  = DATA_I;
                clk_o_nxt = 1'b1;
                of_nxt    = acc.of | OFDET_I;
                uf_nxt    = acc.uf | UFDET_I;
                acc_nxt   = CIC_FLAGS_NONE;
            end else begin
                acc_nxt.of = acc.of | OFDET_I;
                acc_nxt.uf = acc.uf | UFDET_I;
                if (fall_c) begin
                    clk_o_nxt = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge MCLK_I or posedge RST_I) begin
        if (RST_I) begin
            phase_cnt <= '0;
            acc       <= CIC_FLAGS_NONE;
            DATA_O    <= '0;
            CLK_O     <= 1'b0;
            OFDET_O   <= 1'b0;
            UFDET_O   <= 1'b0;
        end else begin
            phase_cnt <= phase_cnt_nxt;
            acc       <= acc_nxt;
            DATA_O    <= data_nxt;
            CLK_O     <= clk_o_nxt;
            OFDET_O   <= of_nxt;
            UFDET_O   <= uf_nxt;
        end
    end

endmodule

// File: tb/tb_cic_decimate_hold.sv
// Bench for cic_decimate_hold: R=4 and R=3 instances checked every MCLK against a sample-index model.
module tb_cic_decimate_hold;

    logic        mclk;
    logic        rst;
    logic        clk_i;
    logic [31:0] data_i;
    logic        of_i;
    logic        uf_i;

    logic        clk_o4, of_o4, uf_o4;
    logic [31:0] data_o4;
    logic        clk_o3, of_o3, uf_o3;
    logic [31:0] data_o3;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Model state per instance: index 0 is R=4, index 1 is R=3
    int unsigned n_s   [2];
    logic [31:0] e_data[2];
    logic        e_clk [2];
    logic        e_of  [2];
    logic        e_uf  [2];
    logic        a_of  [2];
    logic        a_uf  [2];

    cic_decimate_hold #(.DATA_BIT_WIDTH(32), .DECIM_RATIO(4)) dut4 (
        .MCLK_I (mclk),
        .RST_I  (rst),
        .CLK_I  (clk_i),
        .DATA_I (data_i),
        .OFDET_I(of_i),
        .UFDET_I(uf_i),
        .CLK_O  (clk_o4),
        .DATA_O (data_o4),
        .OFDET_O(of_o4),
        .UFDET_O(uf_o4)
    );

    cic_decimate_hold #(.DATA_BIT_WIDTH(32), .DECIM_RATIO(3)) dut3 (
        .MCLK_I (mclk),
        .RST_I  (rst),
        .CLK_I  (clk_i),
        .DATA_I (data_i),
        .OFDET_I(of_i),
        .UFDET_I(uf_i),
        .CLK_O  (clk_o3),
        .DATA_O (data_o3),
        .OFDET_O(of_o3),
        .UFDET_O(uf_o3)
    );

    initial begin
        mclk = 1'b0;
        forever #2 mclk = ~mclk;
    end

    function automatic int unsigned ratio(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            n_s[i] = 0; e_data[i] = '0; e_clk[i] = 1'b0;
            e_of[i] = 1'b0; e_uf[i] = 1'b0; a_of[i] = 1'b0; a_uf[i] = 1'b0;
        end
    endtask

    // n-th rising edge since reset: keep sample when n mod R == 0, drop clock at n mod R == R/2
    task automatic model_rise(input logic [31:0] d, input logic of, input logic uf);
        for (int i = 0; i < 2; i++) begin
            int unsigned r;
            int unsigned pos;
            r   = ratio(i);
            pos = n_s[i] % r;
            if (pos == 0) begin
                e_data[i] = d;
                e_clk[i]  = 1'b1;
                e_of[i]   = a_of[i] | of;
                e_uf[i]   = a_uf[i] | uf;
                a_of[i]   = 1'b0;
                a_uf[i]   = 1'b0;
            end else begin
                a_of[i] = a_of[i] | of;
                a_uf[i] = a_uf[i] | uf;
                if (pos == r / 2) e_clk[i] = 1'b0;
            end
            n_s[i]++;
        end
    endtask

    // One input sample period: CLK_I high 32 MCLK, low 32 MCLK
    task automatic sample(input logic [31:0] d, input logic of, input logic uf);
        @(negedge mclk);
        data_i = d; of_i = of; uf_i = uf; clk_i = 1'b1;
        @(posedge mclk);
        model_rise(d, of, uf);
        repeat (32) @(negedge mclk);
        clk_i = 1'b0; of_i = 1'b0; uf_i = 1'b0;
        repeat (31) @(negedge mclk);
    endtask

    // Every-cycle compare, sampled between the active edge and the stimulus edge
    always @(posedge mclk) begin
        #1;
        if (cmp_en) begin
            chk("r4_data", data_o4, e_data[0]);
            chk("r4_clk",  32'(clk_o4), 32'(e_clk[0]));
            chk("r4_of",   32'(of_o4),  32'(e_of[0]));
            chk("r4_uf",   32'(uf_o4),  32'(e_uf[0]));
            chk("r3_data", data_o3, e_data[1]);
            chk("r3_clk",  32'(clk_o3), 32'(e_clk[1]));
            chk("r3_of",   32'(of_o3),  32'(e_of[1]));
            chk("r3_uf",   32'(uf_o3),  32'(e_uf[1]));
        end
    end

    initial begin
        rst = 1'b1; clk_i = 1'b0; data_i = '0; of_i = 1'b0; uf_i = 1'b0;
        model_reset();
        repeat (3) @(negedge mclk);
        chk("reset_data4", data_o4, 32'd0);
        chk("reset_clk4",  32'(clk_o4), 32'd0);
        chk("reset_flags4", 32'({of_o4, uf_o4}), 32'd0);
        chk("reset_data3", data_o3, 32'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Ramp with overflow on sample 7 and underflow on sample 11
        for (int k = 1; k <= 16; k++) begin
            sample(32'(k), k == 7, k == 11);
            case (k)
                1:  begin chk("cap1_data4", data_o4, 32'd1); chk("cap1_clk4", 32'(clk_o4), 32'd1);
                          chk("cap1_data3", data_o3, 32'd1); end
                2:  begin chk("k2_clk4", 32'(clk_o4), 32'd1); chk("k2_clk3", 32'(clk_o3), 32'd0); end
                3:  chk("k3_clk4_fall", 32'(clk_o4), 32'd0);
                4:  chk("cap4_data3", data_o3, 32'd4);
                5:  begin chk("cap5_data4", data_o4, 32'd5); chk("cap5_of4", 32'(of_o4), 32'd0); end
                7:  begin chk("cap7_data3", data_o3, 32'd7); chk("cap7_of3_same_edge", 32'(of_o3), 32'd1); end
                9:  begin chk("cap9_data4", data_o4, 32'd9); chk("cap9_of4", 32'(of_o4), 32'd1); end
                13: begin chk("cap13_data4", data_o4, 32'd13); chk("cap13_of4_clear", 32'(of_o4), 32'd0);
                          chk("cap13_uf4", 32'(uf_o4), 32'd1); chk("cap13_uf3", 32'(uf_o3), 32'd1); end
                default: ;
            endcase
        end

        // Reset two edges into a window; outputs clear asynchronously
        sample(32'd17, 1'b0, 1'b0);
        sample(32'd18, 1'b1, 1'b1);
        @(negedge mclk);
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_data4", data_o4, 32'd0);
        chk("async_rst_clk4",  32'(clk_o4), 32'd0);
        chk("async_rst_data3", data_o3, 32'd0);
        repeat (5) @(negedge mclk);
        rst = 1'b0;
        sample(32'd19, 1'b0, 1'b0);
        chk("post_rst_data4", data_o4, 32'd19);
        chk("post_rst_clk4",  32'(clk_o4), 32'd1);
        chk("post_rst_of4",   32'(of_o4), 32'd0);
        chk("post_rst_data3", data_o3, 32'd19);
        for (int k = 20; k <= 24; k++) sample(32'(k), 1'b0, 1'b0);

        // Release reset with CLK_I already high: not an edge
        @(negedge mclk);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge mclk);
        clk_i = 1'b1; data_i = 32'd50;
        repeat (4) @(negedge mclk);
        rst = 1'b0;
        repeat (20) @(negedge mclk);
        chk("high_release_data4", data_o4, 32'd0);
        chk("high_release_clk4",  32'(clk_o4), 32'd0);
        chk("high_release_data3", data_o3, 32'd0);
        clk_i = 1'b0;
        repeat (31) @(negedge mclk);
        sample(32'd51, 1'b0, 1'b0);
        chk("true_edge_data4", data_o4, 32'd51);
        chk("true_edge_clk4",  32'(clk_o4), 32'd1);
        for (int k = 52; k <= 58; k++) sample(32'(k), 1'b0, 1'b0);

        // Static CLK_I: outputs hold
        repeat (300) @(negedge mclk);
        chk("hold_data4", data_o4, 32'd55);
        chk("hold_clk4",  32'(clk_o4), 32'd0);
        chk("hold_data3", data_o3, 32'd57);
        chk("hold_clk3",  32'(clk_o3), 32'd0);

        cmp_en = 1'b0;
        @(negedge mclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
